// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle for regfile_wb_arbiter.
// Carries the two requester channels: port A (ALU results) and port B (load results).
//   master : requester side, drives valid/rd/data and observes ready
//   slave  : arbiter side, observes valid/rd/data and drives ready
interface regfile_wb_arbiter_if #(
  parameter int unsigned XLEN = 64
);
  localparam int unsigned RIDX_W = 5;

  logic              a_valid;
  logic [RIDX_W-1:0] a_rd;
  logic [XLEN-1:0]   a_data;
  logic              a_ready;

  logic              b_valid;
  logic [RIDX_W-1:0] b_rd;
  logic [XLEN-1:0]   b_data;
  logic              b_ready;

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy scoreboard in front of the 32 x XLEN register file.
// Shares the file's single write port between the ALU (A) and load (B) requesters
// with round-robin arbitration, and tracks pending writes per architectural register.
// x0 is never written and never marked busy.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   wb (slave)         A/B write-back requests and their ready handshakes
//   rsv_valid, rsv_rd  issue reservation (marks rsv_rd busy)
//   flush              synchronous clear of all busy bits
//   chk_ra, chk_rb     hazard query indices
//   busy_a, busy_b     combinational busy status of chk_ra / chk_rb
//   we, rw, Din        registered register-file write port
//
// Optional feature: define REGFILE_ARB_BYPASS_EN to add fwd_a_hit/fwd_a_data and
// fwd_b_hit/fwd_b_data, which expose the in-flight write to the hazard queries and
// mask the matching busy bit.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  regfile_wb_arbiter_if.slave   wb,
  input  logic                  rsv_valid,
  input  logic [4:0]            rsv_rd,
  input  logic                  flush,
  input  logic [4:0]            chk_ra,
  input  logic [4:0]            chk_rb,
  output logic                  busy_a,
  output logic                  busy_b,
`ifdef REGFILE_ARB_BYPASS_EN
  output logic                  fwd_a_hit,
  output logic [XLEN-1:0]       fwd_a_data,
  output logic                  fwd_b_hit,
  output logic [XLEN-1:0]       fwd_b_data,
`endif
  output logic                  we,
  output logic [4:0]            rw,
  output logic [XLEN-1:0]       Din
);

  localparam int unsigned RIDX_W = 5;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  port_e            last_q;
  logic             grant_a;
  logic             grant_b;
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;

  // Round-robin grant: a lone requester wins; on contention the port not granted last wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset_n) begin
      if (wb.a_valid && (!wb.b_valid || (last_q == PORT_B))) begin
        grant_a = 1'b1;
      end else if (wb.b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign wb.a_ready = grant_a;
  assign wb.b_ready = grant_b;

  // Write port register; rw/Din hold when idle, x0 requests are consumed with we low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we     <= 1'b0;
      rw     <= '0;
      Din    <= '0;
      last_q <= PORT_B;
    end else begin
      we <= 1'b0;
      if (grant_a) begin
        we     <= (wb.a_rd != RIDX_W'(0));
        rw     <= wb.a_rd;
        Din    <= wb.a_data;
        last_q <= PORT_A;
      end else if (grant_b) begin
        we     <= (wb.b_rd != RIDX_W'(0));
        rw     <= wb.b_rd;
        Din    <= wb.b_data;
        last_q <= PORT_B;
      end
    end
  end

  // Scoreboard update: retire clear, then younger reservation wins, flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (we) begin
      busy_d[rw] = 1'b0;
    end
    if (rsv_valid && (rsv_rd != RIDX_W'(0))) begin
      busy_d[rsv_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef REGFILE_ARB_BYPASS_EN
  // The in-flight write satisfies a matching query, so its busy bit is masked.
  assign fwd_a_hit  = we && (rw == chk_ra) && (chk_ra != RIDX_W'(0));
  assign fwd_b_hit  = we && (rw == chk_rb) && (chk_rb != RIDX_W'(0));
  assign fwd_a_data = Din;
  assign fwd_b_data = Din;
  assign busy_a     = busy_q[chk_ra] & ~fwd_a_hit;
  assign busy_b     = busy_q[chk_rb] & ~fwd_b_hit;
`else
  assign busy_a     = busy_q[chk_ra];
  assign busy_b     = busy_q[chk_rb];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a per-cycle vector table of requests and expected
// ready/busy values, plus a queue of expected write-port values pushed when a
// request is driven and popped one cycle later.
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN = 64;

  logic              clk;
  logic              reset_n;
  logic              rsv_valid;
  logic [4:0]        rsv_rd;
  logic              flush;
  logic [4:0]        chk_ra;
  logic [4:0]        chk_rb;
  logic              busy_a;
  logic              busy_b;
  logic              we;
  logic [4:0]        rw;
  logic [XLEN-1:0]   Din;
`ifdef REGFILE_ARB_BYPASS_EN
  logic              fwd_a_hit;
  logic [XLEN-1:0]   fwd_a_data;
  logic              fwd_b_hit;
  logic [XLEN-1:0]   fwd_b_data;
`endif

  regfile_wb_arbiter_if #(.XLEN(XLEN)) wb ();

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wb         (wb),
    .rsv_valid  (rsv_valid),
    .rsv_rd     (rsv_rd),
    .flush      (flush),
    .chk_ra     (chk_ra),
    .chk_rb     (chk_rb),
    .busy_a     (busy_a),
    .busy_b     (busy_b),
`ifdef REGFILE_ARB_BYPASS_EN
    .fwd_a_hit  (fwd_a_hit),
    .fwd_a_data (fwd_a_data),
    .fwd_b_hit  (fwd_b_hit),
    .fwd_b_data (fwd_b_data),
`endif
    .we         (we),
    .rw         (rw),
    .Din        (Din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [63:0] ad;
    logic        bv;
    logic [4:0]  brd;
    logic [63:0] bd;
    logic        rv;
    logic [4:0]  rrd;
    logic        fl;
    logic [4:0]  cra;
    logic [4:0]  crb;
    logic        ea;
    logic        eb;
    logic        eba;
    logic        ebb;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rw;
    logic [63:0] din;
  } wr_t;

  vec_t vecs[$];
  wr_t  exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [4:0]  m_rw  = '0;
  logic [63:0] m_din = '0;

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [63:0] ad,
                              logic bv, logic [4:0] brd, logic [63:0] bd,
                              logic rv, logic [4:0] rrd, logic fl,
                              logic [4:0] cra, logic [4:0] crb,
                              logic ea, logic eb, logic eba, logic ebb);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.bv = bv; v.brd = brd; v.bd = bd;
    v.rv = rv; v.rrd = rrd; v.fl = fl;
    v.cra = cra; v.crb = crb;
    v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    wb.a_valid = v.av; wb.a_rd = v.ard; wb.a_data = v.ad;
    wb.b_valid = v.bv; wb.b_rd = v.brd; wb.b_data = v.bd;
    rsv_valid  = v.rv; rsv_rd  = v.rrd; flush = v.fl;
    chk_ra     = v.cra; chk_rb = v.crb;
  endtask

  task automatic check_write(input string tag, output wr_t cur);
    cur.we = 1'b0; cur.rw = m_rw; cur.din = m_din;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s queue: no expected write available", tag);
    end else begin
      cur = exp_q.pop_front();
      chk({tag, " we"},  64'(we),  64'(cur.we));
      chk({tag, " rw"},  64'(rw),  64'(cur.rw));
      chk({tag, " Din"}, 64'(Din), cur.din);
    end
  endtask

  initial begin
    wr_t  cur;
    vec_t idle;
    logic hit_a, hit_b;

    idle = mk(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0);

    // Contention with a reservation of x1 that retires on the first grant
    vecs.push_back(mk(1,1,64'hA1, 1,2,64'hB2, 1,1,0, 1,2, 1,0,0,0));
    vecs.push_back(mk(1,1,64'hA1, 1,2,64'hB2, 0,0,0, 1,2, 0,1,1,0));
    vecs.push_back(mk(1,1,64'hA1, 1,2,64'hB2, 0,0,0, 1,2, 1,0,0,0));
    vecs.push_back(mk(1,1,64'hA1, 1,2,64'hB2, 0,0,0, 1,2, 0,1,0,0));
    // Reserve x7, write 0xDEAD to it, busy clears the cycle after the write
    vecs.push_back(mk(0,0,0, 0,0,0, 1,7,0, 7,2, 0,0,0,0));
    vecs.push_back(mk(1,7,64'hDEAD, 0,0,0, 0,0,0, 7,2, 1,0,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 7,2, 0,0,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 7,2, 0,0,0,0));
    // x0 write from B is consumed without a write enable
    vecs.push_back(mk(0,0,0, 1,0,64'h1, 0,0,0, 0,0, 0,1,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,5, 0,0,0,0));
    // Set/clear collision on x9: reservation wins
    vecs.push_back(mk(0,0,0, 0,0,0, 1,9,0, 9,0, 0,0,0,0));
    vecs.push_back(mk(1,9,64'h99, 0,0,0, 0,0,0, 9,0, 1,0,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,9,0, 9,0, 0,0,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 9,0, 0,0,1,0));
    // Same collision with flush: everything clears, write still delivered
    vecs.push_back(mk(1,9,64'h9A, 0,0,0, 1,4,0, 9,4, 1,0,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,9,1, 9,4, 0,0,1,1));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 9,4, 0,0,0,0));
    // Contention after an A grant: B goes first
    vecs.push_back(mk(1,3,64'h33, 1,5,64'h55, 0,0,0, 3,5, 0,1,0,0));
    vecs.push_back(mk(1,3,64'h33, 0,0,0, 0,0,0, 3,5, 1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 3,5, 0,0,0,0));
    vecs.push_back(idle);

    // Reset held with a pending request
    apply(idle);
    reset_n = 1'b0;
    wb.a_valid = 1'b1; wb.a_rd = 5'd5; wb.a_data = 64'h1234;
    chk_ra = 5'd5;
    #3;
    chk("reset a_ready", 64'(wb.a_ready), 64'(0));
    chk("reset we",      64'(we),         64'(0));
    chk("reset rw",      64'(rw),         64'(0));
    chk("reset Din",     Din,             64'(0));
    chk("reset busy_a",  64'(busy_a),     64'(0));
    apply(idle);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    cur.we = 1'b0; cur.rw = '0; cur.din = '0;
    exp_q.push_back(cur);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      check_write($sformatf("row%0d", i), cur);
      apply(vecs[i]);
      #1;
      hit_a = 1'b0;
      hit_b = 1'b0;
`ifdef REGFILE_ARB_BYPASS_EN
      hit_a = cur.we && (cur.rw == vecs[i].cra) && (vecs[i].cra != 5'd0);
      hit_b = cur.we && (cur.rw == vecs[i].crb) && (vecs[i].crb != 5'd0);
      chk($sformatf("row%0d fwd_a_hit", i), 64'(fwd_a_hit), 64'(hit_a));
      chk($sformatf("row%0d fwd_b_hit", i), 64'(fwd_b_hit), 64'(hit_b));
      if (hit_a) chk($sformatf("row%0d fwd_a_data", i), fwd_a_data, cur.din);
      if (hit_b) chk($sformatf("row%0d fwd_b_data", i), fwd_b_data, cur.din);
`endif
      chk($sformatf("row%0d a_ready", i), 64'(wb.a_ready), 64'(vecs[i].ea));
      chk($sformatf("row%0d b_ready", i), 64'(wb.b_ready), 64'(vecs[i].eb));
      chk($sformatf("row%0d busy_a", i),  64'(busy_a), 64'(vecs[i].eba & ~hit_a));
      chk($sformatf("row%0d busy_b", i),  64'(busy_b), 64'(vecs[i].ebb & ~hit_b));
      if (vecs[i].ea) begin
        m_rw = vecs[i].ard; m_din = vecs[i].ad;
        cur.we = (vecs[i].ard != 5'd0);
      end else if (vecs[i].eb) begin
        m_rw = vecs[i].brd; m_din = vecs[i].bd;
        cur.we = (vecs[i].brd != 5'd0);
      end else begin
        cur.we = 1'b0;
      end
      cur.rw = m_rw; cur.din = m_din;
      exp_q.push_back(cur);
    end

    @(posedge clk);
    #1;
    check_write("final", cur);

    // Reset in the middle of a write: write dropped, reservation lost
    rsv_valid = 1'b1; rsv_rd = 5'd5; chk_ra = 5'd5;
    @(posedge clk);
    #1;
    rsv_valid = 1'b0;
    chk("midrst busy_a set", 64'(busy_a), 64'(1));
    wb.a_valid = 1'b1; wb.a_rd = 5'd5; wb.a_data = 64'h77;
    #1;
    chk("midrst a_ready", 64'(wb.a_ready), 64'(1));
    @(posedge clk);
    #1;
    wb.a_valid = 1'b0;
    chk("midrst we issued", 64'(we), 64'(1));
    chk("midrst rw issued", 64'(rw), 64'(5));
    reset_n = 1'b0;
    #1;
    chk("midrst we dropped", 64'(we),     64'(0));
    chk("midrst busy_a lost", 64'(busy_a), 64'(0));
    chk("midrst Din cleared", Din,         64'(0));
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst we",     64'(we),     64'(0));
    chk("postrst busy_a", 64'(busy_a), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and busy scoreboard in front of the 32 x 64-bit register file. It shares the file's single write port (`we`/`rw`/`Din`) between two write-back requesters: port A for ALU results and port B for load results. It also tracks which architectural registers have a pending write, so that issue logic can stall on read-after-write hazards. It sits between execute/memory write-back and the register file; x0 is never written and never marked busy.

## Interface
- `XLEN`, default 64: data width; must match the register file `Din`.
- `NREG`, default 32: register count; the index is fixed at 5 bits, so only 32 is legal.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  ALU write-back request.
- `a_rd`  in  5  ALU destination register.
- `a_data`  in  XLEN  ALU result.
- `a_ready`  out  1  ALU request accepted this cycle.
- `b_valid`  in  1  load write-back request.
- `b_rd`  in  5  load destination register.
- `b_data`  in  XLEN  load data.
- `b_ready`  out  1  load request accepted this cycle.
- `rsv_valid`  in  1  issue reserves `rsv_rd` (marks it busy).
- `rsv_rd`  in  5  register being reserved.
- `flush`  in  1  synchronous clear of every busy bit.
- `chk_ra`  in  5  hazard query index A.
- `chk_rb`  in  5  hazard query index B.
- `busy_a`  out  1  `chk_ra` has a pending write (combinational).
- `busy_b`  out  1  `chk_rb` has a pending write (combinational).
- `we`  out  1  register-file write enable (registered).
- `rw`  out  5  register-file write index (registered).
- `Din`  out  XLEN  register-file write data (registered).

## Operation
- Handshake: a transfer happens on a rising edge where `x_valid & x_ready` is true.
  - Requesters hold `valid`, `rd` and `data` stable until accepted.
  - `ready` never depends on `ready`.
- Arbitration: at most one grant per cycle.
  - Only one valid requester: it is granted.
  - Both valid: round-robin. A 1-bit pointer `last` holds the last granted port, and the other port wins.
  - `last` updates on every grant.
  - `a_ready`/`b_ready` are combinational from `a_valid`, `b_valid` and `last`, and are 0 while `reset_n` is low.
- Write issue: the accepted `rd`/`data` are registered onto `rw`/`Din`, with `we = (rd != 0)`.
  - A request to x0 is accepted and consumed but produces `we = 0`.
  - With no grant, `we` is 0 and `rw`/`Din` hold their previous values.
- Scoreboard: `busy[31:1]`, where `busy[0]` is constantly 0.
  - Set: on an edge with `rsv_valid` and `rsv_rd != 0`, `busy[rsv_rd] <= 1`.
  - Clear: on an edge where `we` is 1, `busy[rw] <= 0`. This is the same edge on which the register file captures the data.
  - Set and clear of the same index on the same edge: set wins, because a new reservation is younger than the retiring write.
  - `flush` clears all bits and has priority over set; the in-flight `we`/`rw`/`Din` is still delivered.
- `busy_a = busy[chk_ra]`, `busy_b = busy[chk_rb]`; both read 0 for index 0.
- No internal check of a write to an unreserved register: the write is still issued and its clear is a no-op.

## Timing
- Reset (asynchronous assert, sampled deassert) gives `we=0`, `rw=0`, `Din=0`, `busy=0`, and `last=B` so that A wins the first contention.
- Write latency: a handshake at edge N gives `we`/`rw`/`Din` valid during cycle N+1; the register file writes at edge N+1.
- Busy clears at edge N+1, so a reader sees `busy=0` from cycle N+2 and the file already holds the new value.
- Throughput: one write per cycle sustained; two contending requesters alternate cycle by cycle.
- Reserve to busy: `rsv_valid` at edge M gives `busy` visible in cycle M+1.
- Reset mid-operation: an in-flight write is dropped (`we` forced to 0) and all reservations are lost.

## Configuration
- `REGFILE_ARB_BYPASS_EN` defined: adds outputs `fwd_a_hit`, `fwd_a_data`, `fwd_b_hit` and `fwd_b_data`.
  - `fwd_x_hit = we & (rw == chk_rx) & (chk_rx != 0)` and `fwd_x_data = Din`.
  - While a hit is asserted, `busy_x` is forced to 0, so issue can proceed one cycle early using the forwarded data.
- `REGFILE_ARB_BYPASS_EN` not defined: the forwarding ports do not exist and `busy_x` is exactly the scoreboard bit.

## Test plan
- Reset: hold `reset_n=0` with `a_valid=1` -> `a_ready=0`, `we=0`, `rw=0`, `Din=0`, and `busy_a=0` for `chk_ra=5`.
- Single write: `rsv_valid` with `rsv_rd=7`, then `a_valid` with `a_rd=7`, `a_data=64'hDEAD` -> `we=1`, `rw=7`, `Din=64'hDEAD` one cycle later; `busy[7]` reads 1 until then and 0 the cycle after.
- Contention: `a_valid` and `b_valid` held for 4 cycles with `a_rd=1`, `b_rd=2` -> grants A,B,A,B; `rw` sequence 1,2,1,2.
- x0 write: `b_valid` with `b_rd=0`, `b_data=64'h1` -> `b_ready=1`; the next cycle has `we=0` and `busy_a=0` for `chk_ra=0`.
- Set/clear collision: `rw=9` with `we=1` on the same edge as `rsv_valid` with `rsv_rd=9` -> `busy[9]=1` afterwards. Repeating with `flush=1` -> all busy bits 0.
- Bypass (`REGFILE_ARB_BYPASS_EN`): `chk_ra=7` while `we=1`, `rw=7`, `Din=64'h55` -> `fwd_a_hit=1`, `fwd_a_data=64'h55`, `busy_a=0`.
